// File: rtl/seg_mult_pkg.sv
// rtl/seg_mult_pkg.sv - shared types and helpers for the segmented multiplier
package seg_mult_pkg;

    localparam int MAX_W = 16;
    localparam int PP_W  = 2 * MAX_W;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Partial products are carried at the widest legal size; the top trims them.
    typedef struct packed {
        logic [PP_W-1:0] p_hh;
        logic [PP_W-1:0] p_x;
        logic [PP_W-1:0] p_ll_exact;
        logic [PP_W-1:0] p_ll;
        logic            approx;
    } s2_payload_t;

    function automatic logic [PP_W-1:0] approx_ll(input logic [MAX_W-1:0] al,
                                                  input logic [MAX_W-1:0] bl);
        return PP_W'(al & bl);
    endfunction

endpackage

// File: rtl/seg_pp_gen.sv
// rtl/seg_pp_gen.sv - combinational partial-product generator between S1 and S2
module seg_pp_gen
    import seg_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             approx,
    output s2_payload_t      pp
);

    localparam int HW = WIDTH - K;

    logic [HW-1:0]   ah;
    logic [HW-1:0]   bh;
    logic [K-1:0]    al;
    logic [K-1:0]    bl;
    logic [PP_W-1:0] ll_exact;
    logic [PP_W-1:0] ll_apx;

    assign ah = a[WIDTH-1:K];
    assign bh = b[WIDTH-1:K];
    assign al = a[K-1:0];
    assign bl = b[K-1:0];

    assign ll_exact = PP_W'(al) * PP_W'(bl);
    assign ll_apx   = approx_ll(MAX_W'(al), MAX_W'(bl));

    always_comb begin
        pp            = '0;
        pp.p_hh       = PP_W'(ah) * PP_W'(bh);
        pp.p_x        = PP_W'(ah) * PP_W'(bl) + PP_W'(al) * PP_W'(bh);
        pp.p_ll_exact = ll_exact;
        pp.p_ll       = approx ? ll_apx : ll_exact;
        pp.approx     = approx;
    end

endmodule

// File: rtl/seg_mult_pipe.sv
// rtl/seg_mult_pipe.sv - three-stage segmented multiplier with exact/approximate low term
module seg_mult_pipe
    import seg_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic                  in_approx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_y,
    output logic [2*K-1:0]        out_err,
    output logic                  out_approx,
    output logic [CNT_W-1:0]      approx_cnt,
    input  logic                  cnt_clr
);

    localparam int PW = prod_w(WIDTH);

    logic             v1, v2, v3;
    logic             adv;
    logic [WIDTH-1:0] a1, b1;
    logic             apx1;
    s2_payload_t      pp;
    s2_payload_t      s2_q;
    logic [PW-1:0]    y_next;
    logic [2*K-1:0]   err_next;
    logic             out_hs;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign out_hs    = v3 && out_ready;

    seg_pp_gen #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_pp_gen (
        .a      (a1),
        .b      (b1),
        .approx (apx1),
        .pp     (pp)
    );

    assign y_next   = PW'(s2_q.p_hh << (2 * K)) + PW'(s2_q.p_x << K) + PW'(s2_q.p_ll);
    assign err_next = (2*K)'(s2_q.p_ll_exact - s2_q.p_ll);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            a1         <= '0;
            b1         <= '0;
            apx1       <= 1'b0;
            s2_q       <= '0;
            out_y      <= '0;
            out_err    <= '0;
            out_approx <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= in_a;
                b1   <= in_b;
                apx1 <= in_approx;
            end
            v2 <= v1;
            if (v1) begin
                s2_q <= pp;
            end
            v3 <= v2;
            if (v2) begin
                out_y      <= y_next;
                out_err    <= err_next;
                out_approx <= s2_q.approx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            approx_cnt <= '0;
        end else if (out_hs && out_approx && (approx_cnt != '1)) begin
            approx_cnt <= approx_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_mult_pipe.sv
// tb/tb_seg_mult_pipe.sv - directed self-checking bench for seg_mult_pipe
module tb_seg_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_approx = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;

    logic        in_ready, out_valid, out_approx;
    logic [15:0] out_y;
    logic [5:0]  out_err;
    logic [15:0] approx_cnt;

    logic        in_ready1, out_valid1, out_approx1;
    logic [15:0] out_y1;
    logic [5:0]  out_err1;
    logic [1:0]  approx_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_mult_pipe #(.WIDTH(8), .K(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_err(out_err), .out_approx(out_approx),
        .approx_cnt(approx_cnt), .cnt_clr(cnt_clr)
    );

    seg_mult_pipe #(.WIDTH(8), .K(3), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid1), .out_ready(out_ready), .out_y(out_y1),
        .out_err(out_err1), .out_approx(out_approx1),
        .approx_cnt(approx_cnt1), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic apx);
        chk("send_ready", 32'(in_ready), 32'd1);
        in_a      = a;
        in_b      = b;
        in_approx = apx;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] y,
                              input logic [5:0] err, input logic apx, output int lat);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        lat = n;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_y"}, 32'(out_y), 32'(y));
        chk({tag, "_err"}, 32'(out_err), 32'(err));
        chk({tag, "_apx"}, 32'(out_approx), 32'(apx));
        chk({tag, "_c2"}, {out_valid1, out_approx1, out_err1, 8'h00, out_y1},
            {1'b1, apx, err, 8'h00, y});
        tick();
    endtask

    initial begin
        logic [7:0]  va [5];
        logic [7:0]  vb [5];
        logic        vx [5];
        logic [15:0] vy [5];
        logic [5:0]  ve [5];
        int          lat;
        int          sent;
        int          rcv;
        int          stale;
        logic        held;
        logic [15:0] held_y;
        logic        saw_stall;

        va = '{8'h03, 8'h12, 8'h80, 8'h0F, 8'hFF};
        vb = '{8'h05, 8'h34, 8'h02, 8'h0E, 8'h01};
        vx = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vy = '{16'h000F, 16'h03A0, 16'h0100, 16'h00AE, 16'h00FF};
        ve = '{6'd0, 6'd8, 6'd0, 6'd36, 6'd0};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(out_y), 32'd0);
        chk("rst_err_apx", {out_err, out_approx}, 32'd0);
        chk("rst_cnt", 32'(approx_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_c2", {in_ready1, out_valid1, approx_cnt1}, {1'b1, 1'b0, 2'b00});

        send1(8'hB7, 8'h5D, 1'b0);
        get_result("exact_b7", 16'h427B, 6'd0, 1'b0, lat);
        chk("latency", 32'(lat), 32'd2);
        chk("cnt_after_exact", 32'(approx_cnt), 32'd0);

        send1(8'hB7, 8'h5D, 1'b1);
        get_result("apx_b7", 16'h425D, 6'd30, 1'b1, lat);
        chk("cnt_after_apx", 32'(approx_cnt), 32'd1);

        send1(8'hFF, 8'hFF, 1'b0);
        get_result("exact_ff", 16'hFE01, 6'd0, 1'b0, lat);
        send1(8'hFF, 8'hFF, 1'b1);
        get_result("apx_ff", 16'hFDD7, 6'd42, 1'b1, lat);
        send1(8'h00, 8'hFF, 1'b0);
        get_result("exact_zero", 16'h0000, 6'd0, 1'b0, lat);
        send1(8'h00, 8'hFF, 1'b1);
        get_result("apx_zero", 16'h0000, 6'd0, 1'b1, lat);
        chk("cnt_three", 32'(approx_cnt), 32'd3);
        chk("c2_cnt_three", 32'(approx_cnt1), 32'd3);

        sent = 0;
        rcv = 0;
        held = 1'b0;
        held_y = '0;
        saw_stall = 1'b0;
        for (int c = 0; c < 40 && rcv < 5; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_a      = va[sent];
                in_b      = vb[sent];
                in_approx = vx[sent];
            end
            #1;
            if (held) chk("bp_hold_y", 32'(out_y), 32'(held_y));
            if (!out_ready && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                chk("bp_y", 32'(out_y), 32'(vy[rcv]));
                chk("bp_err_apx", {out_err, out_approx}, {ve[rcv], vx[rcv]});
                rcv++;
            end
            held   = out_valid && !out_ready;
            held_y = out_y;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(rcv), 32'd5);
        chk("bp_stall_seen", 32'(saw_stall), 32'd1);
        tick();
        chk("bp_no_extra", 32'(out_valid), 32'd0);
        chk("cnt_five", 32'(approx_cnt), 32'd5);
        chk("c2_cnt_sat", 32'(approx_cnt1), 32'd3);

        send1(8'h12, 8'h34, 1'b1);
        lat = 0;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("clr_valid", 32'(out_valid), 32'd1);
        chk("clr_y", 32'(out_y), 32'h03A0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(approx_cnt), 32'd0);
        chk("clr_c2_cnt", 32'(approx_cnt1), 32'd0);
        chk("clr_consumed", 32'(out_valid), 32'd0);

        send1(8'h0F, 8'h0E, 1'b1);
        get_result("apx_0f", 16'h00AE, 6'd36, 1'b1, lat);
        chk("cnt_before_rst", 32'(approx_cnt), 32'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a      = va[i];
            in_b      = vb[i];
            in_approx = 1'b1;
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outs", {out_y, out_err, out_approx}, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(approx_cnt), 32'd0);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stale++;
            tick();
        end
        chk("no_stale", 32'(stale), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
